// File: rtl/fe_dispatch_queue_if.sv
// Front-end to back-end dispatch bundle: decoded-instruction handshake in,
// valid/yumi head out, and the redirect path back toward the front end.
interface fe_dispatch_queue_if #(
   parameter int WIDTH_P     = 32,
   parameter int DEPTH_P     = 8,
   parameter int WORD_SIZE_P = 16
);
   localparam int CNT_W = $clog2(DEPTH_P) + 1;

   logic                   fe_valid_i;
   logic [WIDTH_P-1:0]     fe_instr_i;
   logic                   fe_ready_o;
   logic                   be_valid_o;
   logic [WIDTH_P-1:0]     be_instr_o;
   logic                   be_yumi_i;
   logic                   redirect_v_i;
   logic [WORD_SIZE_P-1:0] redirect_pc_i;
   logic                   mis_predict_o;
   logic [WORD_SIZE_P-1:0] branch_mis_target_o;
   logic [CNT_W-1:0]       count_o;

   // The queue itself.
   modport slave (
      input  fe_valid_i, fe_instr_i, be_yumi_i, redirect_v_i, redirect_pc_i,
      output fe_ready_o, be_valid_o, be_instr_o, mis_predict_o,
             branch_mis_target_o, count_o
   );

   // Whatever surrounds the queue: front end, back end and redirect source.
   modport master (
      output fe_valid_i, fe_instr_i, be_yumi_i, redirect_v_i, redirect_pc_i,
      input  fe_ready_o, be_valid_o, be_instr_o, mis_predict_o,
             branch_mis_target_o, count_o
   );
endinterface

// File: rtl/fe_dispatch_queue.sv
// Decoded-instruction FIFO between the front end and rename/issue, with a
// flushing redirect path that pulses mis_predict back to the front end.
module fe_dispatch_queue #(
   parameter int WIDTH_P     = 32,  // decoded instruction width
   parameter int DEPTH_P     = 8,
   parameter int WORD_SIZE_P = 16
) (
   input logic                clk_i,
   input logic                reset_n_i,
   fe_dispatch_queue_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH_P);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH_P);

   if (DEPTH_P < 2 || (DEPTH_P & (DEPTH_P - 1)) != 0) begin : g_depth_chk
      $error("fe_dispatch_queue: DEPTH_P must be a power of two >= 2");
   end

   typedef enum logic {
      RUN      = 1'b0,
      REDIRECT = 1'b1
   } state_e;

   state_e                 state_q, state_d;
   logic [PTR_W-1:0]       wptr_q, wptr_d;
   logic [PTR_W-1:0]       rptr_q, rptr_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [WORD_SIZE_P-1:0] target_q, target_d;
   logic [WIDTH_P-1:0]     mem_q [DEPTH_P];

   logic full, empty;
   logic fe_ready, be_valid;
   logic enq, deq;

   // Status and handshake terms come only from registered state, so neither
   // ready nor valid has a combinational path from any input.
   always_comb begin
      full     = (count_q == FULL_CNT);
      empty    = (count_q == '0);
      fe_ready = ~full | (state_q == REDIRECT);
      be_valid = ~empty & (state_q == RUN);
      enq      = bus.fe_valid_i & fe_ready & (state_q == RUN) & ~bus.redirect_v_i;
      deq      = be_valid & bus.be_yumi_i;
   end

   always_comb begin
      state_d  = state_q;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      count_d  = count_q;
      target_d = target_q;

      if (bus.redirect_v_i) begin
         // Flush wins over any same-cycle enqueue or yumi.
         state_d  = REDIRECT;
         target_d = bus.redirect_pc_i;
         wptr_d   = '0;
         rptr_d   = '0;
         count_d  = '0;
      end else begin
         state_d = RUN;
         if (enq) begin
            wptr_d = wptr_q + PTR_W'(1);
         end
         if (deq) begin
            rptr_d = rptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q  <= RUN;
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         target_q <= target_d;
      end
   end

   // Entry storage carries no reset; contents are only observed while valid.
   always_ff @(posedge clk_i) begin
      if (enq) begin
         mem_q[wptr_q] <= bus.fe_instr_i;
      end
   end

   assign bus.fe_ready_o          = fe_ready;
   assign bus.be_valid_o          = be_valid;
   assign bus.be_instr_o          = mem_q[rptr_q];
   assign bus.mis_predict_o       = (state_q == REDIRECT);
   assign bus.branch_mis_target_o = target_q;
   assign bus.count_o             = count_q;

   a_count_bound : assert property (@(posedge clk_i) disable iff (!reset_n_i)
      count_q <= FULL_CNT);
   a_ptr_consistent : assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (wptr_q - rptr_q) == count_q[PTR_W-1:0]);
endmodule
